// File: rtl/multicycle_cpu.sv
// multicycle_cpu: MIPS-subset multicycle core with one shared memory port
// Optional feature: define MCPU_MISALIGN_TRAP_EN to halt on misaligned data addresses or jump targets.
module multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic              halted
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] rf_q [32];
    logic [31:0] simm, zimm, pc4, ea, br_tgt, j_tgt, ctl_tgt, nxt, alu_res, wd, addr;
    logic [5:0]  op, funct;
    logic [4:0]  wa;
    logic is_r, is_alu_r, is_jr, is_addi, is_xori, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic valid, ctl, take, misalign, upd;

    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign simm     = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zimm     = {16'h0, ir_q[15:0]};
    assign pc4      = pc_q + 32'd4;
    assign ea       = a_q + simm;
    assign br_tgt   = pc4 + {simm[29:0], 2'b00};
    assign j_tgt    = {pc4[31:28], ir_q[25:0], 2'b00};
    assign is_r     = op == 6'h00;
    assign is_jr    = is_r && funct == 6'h08;
    assign is_alu_r = is_r && (funct == 6'h20 || funct == 6'h22 || funct == 6'h2a);
    assign is_addi  = op == 6'h08;
    assign is_xori  = op == 6'h0e;
    assign is_lw    = op == 6'h23;
    assign is_sw    = op == 6'h2b;
    assign is_beq   = op == 6'h04;
    assign is_bne   = op == 6'h05;
    assign is_j     = op == 6'h02;
    assign is_jal   = op == 6'h03;
    assign valid    = is_alu_r | is_jr | is_addi | is_xori | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
    assign ctl      = is_beq | is_bne | is_j | is_jr;
    assign take     = is_j | is_jr | (is_beq && a_q == b_q) | (is_bne && a_q != b_q);
    assign ctl_tgt  = is_jr ? a_q : is_j ? j_tgt : take ? br_tgt : pc4;
    assign wa       = is_jal ? 5'd31 : is_r ? ir_q[15:11] : ir_q[20:16];
    assign wd       = is_lw ? mdr_q : alu_q;
`ifdef MCPU_MISALIGN_TRAP_EN
    assign misalign = ((is_lw | is_sw) && ea[1:0] != 2'b00) || (take && ctl_tgt[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // ALU result: JAL link value, immediate ops, effective address or R-type op
    always_comb begin
        alu_res = is_jal ? pc4 :
                  is_xori ? a_q ^ zimm :
                  (is_addi | is_lw | is_sw) ? ea :
                  funct == 6'h22 ? a_q - b_q :
                  funct == 6'h2a ? {31'b0, $signed(a_q) < $signed(b_q)} :
                  a_q + b_q;
    end

    // Next pc: taken only on an instruction's final cycle, always word aligned
    always_comb begin
        nxt  = (state_q == WB && is_jal) ? j_tgt : (state_q == EXEC) ? ctl_tgt : pc4;
        upd  = (state_q == EXEC && ctl && !misalign) || (state_q == MEM && mem_ready && is_sw) || state_q == WB;
        pc_d = upd ? {nxt[31:2], 2'b00} : pc_q;
    end

    // State register
    always_ff @(posedge clk) begin
        state_q <= reset ? FETCH : state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE:  state_d = valid ? EXEC : HALT;
            EXEC:    state_d = misalign ? HALT : ctl ? FETCH : (is_lw | is_sw) ? MEM : WB;
            MEM:     state_d = mem_ready ? (is_lw ? WB : FETCH) : MEM;
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    // Memory port and status outputs; quiet while reset is asserted
    always_comb begin
        mem_req   = !reset && (state_q == FETCH || state_q == MEM);
        mem_we    = mem_req && state_q == MEM && is_sw;
        addr      = state_q == MEM ? {alu_q[31:2], 2'b00} : {pc_q[31:2], 2'b00};
        mem_addr  = mem_req ? addr[ADDR_W-1:0] : '0;
        mem_wdata = mem_we ? b_q : '0;
        pc        = pc_q;
        halted    = state_q == HALT;
    end

    // Datapath registers and register file; r0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (state_q == FETCH && mem_ready) ir_q <= mem_rdata;
            if (state_q == DECODE) begin
                a_q <= rf_q[ir_q[25:21]];
                b_q <= rf_q[ir_q[20:16]];
            end
            if (state_q == EXEC) alu_q <= alu_res;
            if (state_q == MEM && mem_ready) mdr_q <= mem_rdata;
            if (state_q == WB && wa != 5'd0) rf_q[wa] <= wd;
        end
    end
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: scoreboard bench checking every memory transfer plus pc/halt status
module tb_multicycle_cpu;
    logic        clk = 0, reset = 1, load = 0;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [31:0] mem  [0:127];
    logic [31:0] prog [0:127];
    int delay = 0, cnt = 0, checks = 0, errors = 0;

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} xfer_t;
    xfer_t exp_q[$];
    xfer_t last;
    logic  pend = 0;

    multicycle_cpu dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    assign mem_ready = cnt >= delay;
    assign mem_rdata = mem[mem_addr[8:2]];

    // Memory model: program load during reset, stores on completed write transfers, wait-state counter
    always @(posedge clk) begin
        cnt <= (mem_req && !mem_ready) ? cnt + 1 : 0;
        if (load) for (int i = 0; i < 128; i++) mem[i] <= prog[i];
        else if (mem_req && mem_ready && mem_we) mem[mem_addr[8:2]] <= mem_wdata;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: hold-stability during waits, and each completed transfer against the scoreboard
    always @(negedge clk) begin
        if (!reset && pend) begin
            check("hold_req", {31'b0, mem_req}, 32'd1);
            check("hold_addr", mem_addr, last.addr);
            check("hold_we", {31'b0, mem_we}, {31'b0, last.we});
            check("hold_wdata", mem_wdata, last.wdata);
        end
        if (!reset && mem_req && mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got we=%0b addr=%h wdata=%h expected none", mem_we, mem_addr, mem_wdata);
            end else begin
                check("xfer_we", {31'b0, mem_we}, {31'b0, exp_q[0].we});
                check("xfer_addr", mem_addr, exp_q[0].addr);
                check("xfer_wdata", mem_wdata, exp_q[0].wdata);
                void'(exp_q.pop_front());
            end
        end
        pend <= !reset && mem_req && !mem_ready;
        last <= '{mem_we, mem_addr, mem_wdata};
    end

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] a);
        return {op, a};
    endfunction

    task automatic clr();
        for (int i = 0; i < 128; i++) prog[i] = 32'h0;
    endtask
    task automatic push(logic we, logic [31:0] a, logic [31:0] d);
        exp_q.push_back('{we, a, d});
    endtask
    task automatic pf(logic [31:0] a);
        push(1'b0, a, 32'h0);
    endtask

    task automatic start_reset(int dly);
        @(negedge clk);
        reset = 1;
        load  = 1;
        delay = dly;
        exp_q.delete();
        @(negedge clk);
        load = 0;
        @(negedge clk);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'd0);
    endtask
    task automatic release_reset();
        @(posedge clk);
        #1 reset = 0;
        #1 check("req_after_reset", {31'b0, mem_req}, 32'd1);
    endtask
    task automatic wait_done(int budget, bit need_halt);
        int n = 0;
        while (!(exp_q.size() == 0 && (!need_halt || halted)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_in_budget", {31'b0, n < budget}, 32'd1);
    endtask
    task automatic wait_addr(logic [31:0] a, int budget);
        int n = 0;
        @(negedge clk);
        while (!(mem_req && mem_addr == a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("addr_seen", {31'b0, n < budget}, 32'd1);
    endtask

    initial begin
        // ALU ops, wrap, signed SLT, zero-extended XORI, cycle timing, halt on undefined opcode
        clr();
        prog[0] = enc_i(6'h08, 0, 1, 16'd5);
        prog[1] = enc_i(6'h08, 1, 2, 16'hFFF9);
        prog[2] = enc_i(6'h2b, 0, 2, 16'h0080);
        prog[3] = enc_r(1, 2, 3, 6'h22);
        prog[4] = enc_r(2, 1, 4, 6'h2a);
        prog[5] = enc_i(6'h0e, 2, 5, 16'hFFFF);
        prog[6] = enc_r(3, 4, 6, 6'h20);
        prog[7] = enc_i(6'h2b, 0, 5, 16'h0084);
        prog[8] = enc_i(6'h2b, 0, 6, 16'h0088);
        prog[9] = 32'hFC00_0000;
        start_reset(0);
        pf(0); pf(4); pf(8); push(1, 32'h80, 32'hFFFF_FFFE);
        pf(32'hC); pf(32'h10); pf(32'h14); pf(32'h18); pf(32'h1C); push(1, 32'h84, 32'hFFFF_0001);
        pf(32'h20); push(1, 32'h88, 32'h8); pf(32'h24);
        release_reset();
        repeat (4) @(posedge clk);
        @(negedge clk) check("pc_after_4", pc, 32'h4);
        repeat (4) @(posedge clk);
        @(negedge clk) check("pc_after_8", pc, 32'h8);
        wait_done(200, 1);
        check("halt_pc", pc, 32'h24);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_sticky", {30'b0, halted, mem_req}, 32'd2);
        end

        // Store then load with three wait states on every request
        clr();
        prog[0]  = enc_j(6'h02, 26'd16);
        prog[16] = enc_i(6'h08, 0, 2, 16'hFFFE);
        prog[17] = enc_i(6'h2b, 0, 2, 16'h0008);
        prog[18] = enc_i(6'h23, 0, 3, 16'h0008);
        prog[19] = enc_i(6'h2b, 0, 3, 16'h008C);
        prog[20] = 32'hFC00_0000;
        start_reset(3);
        pf(0); pf(32'h40); pf(32'h44); push(1, 32'h8, 32'hFFFF_FFFE);
        pf(32'h48); push(0, 32'h8, 0); pf(32'h4C); push(1, 32'h8C, 32'hFFFF_FFFE); pf(32'h50);
        release_reset();
        wait_done(400, 1);
        check("ls_pc", pc, 32'h50);

        // BEQ r1,r1,-1 loops on itself every three cycles
        clr();
        prog[0] = enc_i(6'h08, 0, 1, 16'd3);
        prog[1] = enc_j(6'h02, 26'd4);
        prog[4] = enc_i(6'h04, 1, 1, 16'hFFFF);
        start_reset(0);
        pf(0); pf(4);
        for (int i = 0; i < 8; i++) pf(32'h10);
        release_reset();
        wait_addr(32'h10, 50);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk) check("beq_gap1", {31'b0, mem_req}, 32'd0);
            @(negedge clk) check("beq_gap2", {31'b0, mem_req}, 32'd0);
            @(negedge clk) check("beq_refetch", mem_req ? mem_addr : 32'hFFFF_FFFF, 32'h10);
        end
        check("beq_pc", pc, 32'h10);
        wait_done(100, 0);

        // BNE r1,r1 falls through
        prog[4] = enc_i(6'h05, 1, 1, 16'hFFFF);
        start_reset(0);
        pf(0); pf(4); pf(32'h10); pf(32'h14);
        release_reset();
        wait_done(100, 1);
        check("bne_pc", pc, 32'h14);

        // JAL links pc+4 into r31, JR returns through it
        clr();
        prog[0]  = enc_i(6'h08, 0, 7, 16'd9);
        prog[1]  = enc_r(0, 0, 0, 6'h20);
        prog[2]  = enc_j(6'h03, 26'h40);
        prog[3]  = 32'hFC00_0000;
        prog[64] = enc_i(6'h2b, 0, 31, 16'h0090);
        prog[65] = enc_r(31, 0, 0, 6'h08);
        start_reset(0);
        pf(0); pf(4); pf(8); pf(32'h100); push(1, 32'h90, 32'hC); pf(32'h104); pf(32'hC);
        release_reset();
        wait_done(100, 1);
        check("jr_pc", pc, 32'hC);

        // Reset during a stalled LW abandons it; registers come back cleared
        clr();
        prog[0]  = enc_i(6'h08, 0, 3, 16'd7);
        prog[1]  = enc_i(6'h23, 0, 3, 16'h0080);
        prog[32] = 32'h0000_1234;
        start_reset(10);
        pf(0); pf(4);
        release_reset();
        wait_addr(32'h80, 200);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("abort_req", {31'b0, mem_req}, 32'd0);
        check("abort_pc", pc, 32'h0);
        check("abort_queue", exp_q.size(), 32'd0);
        clr();
        prog[0] = enc_i(6'h2b, 0, 3, 16'h0094);
        start_reset(0);
        pf(0); push(1, 32'h94, 32'h0); pf(4);
        release_reset();
        wait_done(100, 1);
        check("abort_halt_pc", pc, 32'h4);

        // Misaligned LW address
        clr();
        prog[0] = enc_i(6'h23, 0, 1, 16'd2);
        prog[1] = enc_i(6'h2b, 0, 1, 16'h0098);
        start_reset(0);
`ifdef MCPU_MISALIGN_TRAP_EN
        pf(0);
        release_reset();
        wait_done(100, 1);
        check("mis_pc", pc, 32'h0);
`else
        pf(0); push(0, 32'h0, 0); pf(4); push(1, 32'h98, enc_i(6'h23, 0, 1, 16'd2)); pf(8);
        release_reset();
        wait_done(100, 1);
        check("mis_pc", pc, 32'h8);
`endif
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter ADDR_W, default 32, width of mem_addr (low ADDR_W bits of the byte address).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  memory transfer request.
REQ-006 SHALL have port mem_we  output  1  1 = store, 0 = read (fetch or load).
REQ-007 SHALL have port mem_addr  output  ADDR_W  byte address of transfer.
REQ-008 SHALL have port mem_wdata  output  32  store data.
REQ-009 SHALL have port mem_rdata  input  32  read data, valid in the cycle mem_ready=1.
REQ-010 SHALL have port mem_ready  input  1  transfer completes in any cycle where mem_req=1 and mem_ready=1.
REQ-011 SHALL have port pc  output  32  address of the current instruction.
REQ-012 SHALL have port halted  output  1  core stopped; sticky until reset.

Function
REQ-013 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB and HALT, with one unified memory port.
REQ-014 FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold until mem_ready; then latch IR and go to DECODE.
REQ-015 While mem_req=1, mem_addr, mem_we and mem_wdata SHALL stay stable until mem_ready; mem_req=0 in DECODE, EXEC, WB and HALT.
REQ-016 DECODE: read rs and rt from the internal 32x32 register file; r0 SHALL always read 0, and writes to r0 SHALL be discarded.
REQ-017 SHALL execute ADD (func 0x20), SUB (0x22), SLT (0x2a, signed) and JR (0x08) for opcode 0x00; ADDI 0x08, XORI 0x0e, LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, J 0x02 and JAL 0x03.
REQ-018 Arithmetic SHALL wrap modulo 2^32 with no overflow trap; ADDI, LW, SW and BEQ/BNE SHALL sign-extend imm; XORI SHALL zero-extend imm.
REQ-019 Branch target SHALL be pc+4+(sext(imm)<<2); J/JAL target SHALL be {pc+4[31:28], addr26, 2'b00}; JR target SHALL be rs.
REQ-020 BEQ, BNE, J and JR SHALL update pc in EXEC and return to FETCH, giving 3 cycles at zero wait states.
REQ-021 R-type ALU, ADDI, XORI and JAL SHALL write back in WB, giving 4 cycles; JAL SHALL write pc+4 to r31 and pc SHALL be set to the target.
REQ-022 LW SHALL issue a read at rs+sext(imm) in MEM and write rt in WB (5 cycles); SW SHALL write rt to rs+sext(imm) in MEM, then go to FETCH (4 cycles).
REQ-023 A non-branching instruction SHALL set pc to pc+4 on its final cycle.
REQ-024 An undefined opcode or funct SHALL enter HALT with halted=1, and pc SHALL hold the offending address.
REQ-025 In HALT, no register or memory writes SHALL occur, regardless of mem_ready.

Reset
REQ-026 With reset=1 at posedge, the next state SHALL be: FETCH, pc=RESET_PC, all registers 0, halted=0, IR 0.
REQ-027 Outputs during and after reset SHALL be mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0; mem_req SHALL rise in the first cycle after reset deasserts.
REQ-028 Reset mid-transfer (any state) SHALL abandon the transfer without a register write, and mem_req SHALL be 0 in the following cycle.

Configuration
REQ-029 Macro MCPU_MISALIGN_TRAP_EN: when defined, a LW/SW address with [1:0]!=0, or a jump/branch target with [1:0]!=0, SHALL enter HALT in EXEC with no memory request and no pc update.
REQ-030 Without MCPU_MISALIGN_TRAP_EN, address bits [1:0] SHALL be forced to 0 on mem_addr and on pc updates.

Verification
REQ-031 Reset then ADDI r1,r0,5 and ADDI r2,r1,-7 with mem_ready=1 always -> r2=0xFFFFFFFE, second instruction completes in cycles 5-8.
REQ-032 SW r2,8(r0) then LW r3,8(r0) with mem_ready delayed 3 cycles on every request -> mem_addr/mem_wdata stable while waiting, and r3=0xFFFFFFFE.
REQ-033 BEQ r1,r1,-1 at pc 0x10 -> pc returns to 0x10 every 3 cycles; BNE r1,r1 -> pc=0x14.
REQ-034 JAL 0x40 at pc 0x8 -> r31=0xC, pc=0x100; then JR r31 -> pc=0xC.
REQ-035 Opcode 0x3F -> halted=1, mem_req=0 held for 20 cycles; reset asserted during a stalled LW -> no rt write, pc=RESET_PC.
REQ-036 With MCPU_MISALIGN_TRAP_EN, LW r1,2(r0) -> halted=1 and no mem_req; without it -> read at address 0.
